// File: rtl/finger_seq_pkg.sv
// rtl/finger_seq_pkg.sv - shared types and code helpers for the finger sequencer
package finger_seq_pkg;

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DN} state_t;

  localparam int MAX_FINGER = 64;
  localparam int MAX_CODE_W = 7;

  function automatic logic [MAX_CODE_W-1:0] clamp_code(
    input logic [MAX_CODE_W-1:0] code,
    input logic [MAX_CODE_W-1:0] limit
  );
    return (code > limit) ? limit : code;
  endfunction

  // Bit i is set iff i < code; callers truncate to their finger count.
  function automatic logic [MAX_FINGER-1:0] therm(input logic [MAX_CODE_W-1:0] code);
    logic [MAX_FINGER-1:0] t;
    for (int i = 0; i < MAX_FINGER; i++) begin
      t[i] = (i < int'(code));
    end
    return t;
  endfunction

endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - reloadable down-counter pacing the finger steps
module step_timer #(
  parameter int STEP_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int TW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TW'(STEP_CYC - 1);
    end else if (dec && cnt != '0) begin
      cnt <= cnt - TW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/finger_seq_ctrl.sv
// rtl/finger_seq_ctrl.sv - paced thermometer ramp controller for a finger array
module finger_seq_ctrl
  import finger_seq_pkg::*;
#(
  parameter int NUM_FINGER = 2,
  parameter int STEP_CYC   = 4,
  parameter int CODE_W     = $clog2(NUM_FINGER + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [CODE_W-1:0]     req_code,
  output logic                  req_ready,
  input  logic                  off,
  output logic [NUM_FINGER-1:0] en,
  output logic [CODE_W-1:0]     cur_code,
  output logic                  busy,
  output logic                  done
);

  state_t            state;
  logic [CODE_W-1:0] tgt;
  logic [CODE_W-1:0] req_tgt;
  logic [CODE_W-1:0] code_up;
  logic [CODE_W-1:0] code_dn;
  logic              accept;
  logic              ramping;
  logic              tick_zero;

  assign req_ready = (state == IDLE) && !off;
  assign accept    = req_valid && req_ready;
  assign ramping   = (state != IDLE) && !off;
  assign req_tgt   = CODE_W'(clamp_code(MAX_CODE_W'(req_code), MAX_CODE_W'(NUM_FINGER)));
  assign code_up   = cur_code + CODE_W'(1);
  assign code_dn   = cur_code - CODE_W'(1);

  step_timer #(.STEP_CYC(STEP_CYC)) u_step_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (off),
    .load  (accept || (ramping && tick_zero)),
    .dec   (ramping && !tick_zero),
    .zero  (tick_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_code <= '0;
      tgt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (off) begin
        // Abort without a done pulse; the array drops to all-off next edge.
        state    <= IDLE;
        cur_code <= '0;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (req_valid) begin
              tgt <= req_tgt;
              if (req_tgt > cur_code) begin
                state <= RAMP_UP;
                busy  <= 1'b1;
              end else if (req_tgt < cur_code) begin
                state <= RAMP_DN;
                busy  <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end
          end
          RAMP_UP: begin
            if (tick_zero) begin
              cur_code <= code_up;
              if (code_up == tgt) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          RAMP_DN: begin
            if (tick_zero) begin
              cur_code <= code_dn;
              if (code_dn == tgt) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign en = NUM_FINGER'(therm(MAX_CODE_W'(cur_code)));

endmodule

// File: tb/tb_finger_seq_ctrl.sv
// tb/tb_finger_seq_ctrl.sv - directed self-checking bench for finger_seq_ctrl
module tb_finger_seq_ctrl;

  localparam int NF   = 2;
  localparam int STEP = 4;
  localparam int CW   = $clog2(NF + 1);

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic [CW-1:0] req_code;
  logic          req_ready;
  logic          off;
  logic [NF-1:0] en;
  logic [CW-1:0] cur_code;
  logic          busy;
  logic          done;

  int total;
  int bad;

  finger_seq_ctrl #(.NUM_FINGER(NF), .STEP_CYC(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_code  (req_code),
    .req_ready (req_ready),
    .off       (off),
    .en        (en),
    .cur_code  (cur_code),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Offer a request at a negedge, then follow the expected ramp cycle by cycle.
  // stop_n >= 0 leaves the ramp after the negedge following edge E0+stop_n.
  task automatic do_ramp(input int start, input int code, input int stop_n);
    int tgt, k, last, lim, dir, steps, cur;
    tgt  = (code > NF) ? NF : code;
    k    = (tgt > start) ? tgt - start : start - tgt;
    dir  = (tgt > start) ? 1 : -1;
    last = k * STEP;
    lim  = (stop_n >= 0) ? stop_n : last;
    chk("ready_before_accept", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_code  = CW'(code);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int n = 0; n <= lim; n++) begin
      if (n > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      steps = n / STEP;
      if (steps > k) steps = k;
      cur = start + dir * steps;
      chk("cur_code", 32'(cur_code), 32'(cur));
      chk("en", 32'(en), 32'((1 << cur) - 1));
      chk("busy", 32'(busy), (n < last) ? 32'd1 : 32'd0);
      chk("done", 32'(done), (n == last) ? 32'd1 : 32'd0);
      chk("req_ready", 32'(req_ready), (n < last) ? 32'd0 : 32'd1);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    off       = 1'b0;
    req_valid = 1'b0;
    req_code  = '0;
    repeat (2) @(negedge clk);
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_cur", 32'(cur_code), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);

    do_ramp(0, 2, -1);
    do_ramp(2, 0, -1);
    do_ramp(0, 3, -1);
    do_ramp(2, 1, -1);
    do_ramp(1, 1, -1);
    @(posedge clk);
    @(negedge clk);
    chk("eq_done_clear", 32'(done), 32'd0);
    chk("eq_en_hold", 32'(en), 32'd1);

    // force-off mid-ramp, then off together with a pending request
    do_ramp(1, 0, -1);
    do_ramp(0, 2, 4);
    off = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("off_en", 32'(en), 32'd0);
    chk("off_cur", 32'(cur_code), 32'd0);
    chk("off_busy", 32'(busy), 32'd0);
    chk("off_done", 32'(done), 32'd0);
    chk("off_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b1;
    req_code  = CW'(2);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("off_req_busy", 32'(busy), 32'd0);
      chk("off_req_en", 32'(en), 32'd0);
      chk("off_req_done", 32'(done), 32'd0);
    end
    req_valid = 1'b0;
    off       = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("off_release_busy", 32'(busy), 32'd0);
    chk("off_release_done", 32'(done), 32'd0);

    // asynchronous reset mid-ramp, checked before the next rising edge
    do_ramp(0, 2, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en", 32'(en), 32'd0);
    chk("arst_cur", 32'(cur_code), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_ready", 32'(req_ready), 32'd1);
    do_ramp(0, 1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
